nibble_serial_adder: RTL and testbench

Multi-cycle wide adder that sits directly upstream of the 4-bit ripple-carry slice (RIPPLE_CARRY). It feeds that slice one nibble per cycle and consumes its S/C_OUT.
- Accepts WIDTH-bit operands over a valid/ready handshake.
- Adds them LSB nibble first, registering the carry between nibbles.
- Presents the full sum and carry-out on a held valid/ready output.
- Trades latency for area in datapaths wider than 4 bits.

---
 rtl/nibble_adder_pkg.sv | 20 ++
 rtl/nibble_serial_adder_ripple_carry.sv | 28 ++
 rtl/nibble_serial_adder.sv | 133 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W  : width of one ripple-carry slice step
//   state_t   : control FSM states (IDLE, ADD, DONE)
//   cnt_width : width of the nibble counter for a given nibble count
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-nibble datapath still needs a one-bit counter.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ripple_carry.sv
// 4-bit ripple-carry slice: the only combinational adder in the block.
//   a, b  : 4-bit addends
//   c_in  : carry into bit 0
//   s     : 4-bit sum
//   c_out : carry out of bit 3
module ripple_carry (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder. Operands are accepted over a valid/ready handshake,
// added one nibble per cycle (LSB first) through a single 4-bit ripple-carry
// slice, and the full sum plus carry-out is presented on a held valid/ready
// output.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand set valid
//   in_ready  : block can accept operands this cycle
//   a_in/b_in : WIDTH-bit operands
//   c_in      : carry into the LSB nibble
//   out_valid : sum/c_out valid
//   out_ready : downstream accepts result
//   sum       : registered WIDTH-bit sum
//   c_out     : registered carry-out of the MSB nibble
//   ovf       : signed overflow flag (only when OVERFLOW_FLAG_EN is defined)
// Optional feature macro: OVERFLOW_FLAG_EN
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = cnt_width(NIBBLES);

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t              state;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic                carry;
    logic [CNT_W-1:0]    cnt;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c;
    logic                accept;

    ripple_carry u_slice (
        .a     (op_a[NIBBLE_W-1:0]),
        .b     (op_b[NIBBLE_W-1:0]),
        .c_in  (carry),
        .s     (slice_s),
        .c_out (slice_c)
    );

    // In DONE the retiring result frees the block, so a new set can be
    // taken on the very edge the old one leaves.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef OVERFLOW_FLAG_EN
    logic a_msb;
    logic b_msb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else if (accept) begin
            // Accept only happens from IDLE or DONE; both restart the add.
            op_a      <= a_in;
            op_b      <= b_in;
            carry     <= c_in;
            cnt       <= '0;
            out_valid <= 1'b0;
            state     <= ADD;
`ifdef OVERFLOW_FLAG_EN
            a_msb     <= a_in[WIDTH-1];
            b_msb     <= b_in[WIDTH-1];
`endif
        end else begin
            case (state)
                ADD: begin
                    // Each slice result enters at the top; after NIBBLES
                    // steps the first nibble has reached bit 0.
                    sum   <= {slice_s, sum[WIDTH-1:NIBBLE_W]};
                    carry <= slice_c;
                    op_a  <= op_a >> NIBBLE_W;
                    op_b  <= op_b >> NIBBLE_W;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(NIBBLES - 1)) begin
                        c_out     <= slice_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef OVERFLOW_FLAG_EN
                        // slice_s[3] is the MSB of the final sum.
                        ovf <= (a_msb == b_msb) && (slice_s[NIBBLE_W-1] != a_msb);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        a_in = WIDTH'($urandom);
        b_in = WIDTH'($urandom);
        c_in = 1'($urandom);
    endtask

    // Reference: plain wide-integer arithmetic.
    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    // Reference: signed result outside the representable range.
    function automatic logic ref_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic c);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        return (s > ((64'sd1 <<< (WIDTH - 1)) - 1)) || (s < -(64'sd1 <<< (WIDTH - 1)));
    endfunction

    // Present operands from IDLE and let the next edge accept them.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c);
        int n;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        c_in     = c;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("start_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Called right after the accepting edge; checks latency, result, hold
    // under backpressure, then retires (optionally chaining the next set).
    task automatic finish_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic c, input int hold, input bit chain,
                             input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                             input logic nc);
        logic [WIDTH:0] exp;
        exp = ref_sum(a, b, c);
        out_ready = 1'b0;
        for (int k = 0; k < NIBBLES; k++) begin
            chk("add_out_valid", out_valid, 1'b0);
            chk("add_in_ready", in_ready, 1'b0);
            tick();
        end
        chk("done_out_valid", out_valid, 1'b1);
        chk("sum", sum, exp[WIDTH-1:0]);
        chk("c_out", c_out, exp[WIDTH]);
`ifdef OVERFLOW_FLAG_EN
        chk("ovf", ovf, ref_ovf(a, b, c));
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            scramble_inputs();
            #1;
            chk("hold_in_ready", in_ready, 1'b0);
            tick();
            chk("hold_out_valid", out_valid, 1'b1);
            chk("hold_sum", sum, exp[WIDTH-1:0]);
            chk("hold_c_out", c_out, exp[WIDTH]);
        end
        out_ready = 1'b1;
        in_valid  = chain;
        if (chain) begin
            a_in = na;
            b_in = nb;
            c_in = nc;
        end
        #1;
        chk("retire_in_ready", in_ready, 1'b1);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        scramble_inputs();
        chk("retired_out_valid", out_valid, 1'b0);
        chk("retired_in_ready", in_ready, chain ? 1'b0 : 1'b1);
    endtask

    initial begin
        logic [WIDTH-1:0] a, b, na, nb;
        logic             c, nc;
        bit               chain;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        c_in      = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_c_out", c_out, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // Directed cases.
        start_op(16'h1234, 16'h4321, 1'b0);
        finish_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        start_op(16'hFFFF, 16'h0001, 1'b0);
        finish_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        // Backpressure for 3 cycles, then back-to-back into 0x0F0F+0x00F1.
        finish_op(16'hFFFF, 16'hFFFF, 1'b1, 3, 1'b1, 16'h0F0F, 16'h00F1, 1'b0);
        finish_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        start_op(16'h7FFF, 16'h0001, 1'b0);
        finish_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        start_op(16'h8000, 16'h8000, 1'b0);
        finish_op(16'h8000, 16'h8000, 1'b0, 1, 1'b0, '0, '0, 1'b0);

        // Reset during the second ADD cycle aborts immediately.
        start_op(16'hABCD, 16'h1111, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_sum", sum, '0);
        chk("abort_in_ready", in_ready, 1'b1);
        #2;
        rst_n = 1'b1;
        tick();
        start_op(16'h0001, 16'h0001, 1'b0);
        finish_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        // Randomized operations with random backpressure and chaining.
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        c = 1'($urandom);
        start_op(a, b, c);
        for (int i = 0; i < 40; i++) begin
            chain = 1'($urandom);
            na = WIDTH'($urandom);
            nb = WIDTH'($urandom);
            nc = 1'($urandom);
            if (i % 7 == 0) na = '1;
            if (i % 5 == 0) nb = '1;
            if (i == 39) chain = 1'b0;
            finish_op(a, b, c, int'($urandom_range(0, 3)), chain, na, nb, nc);
            a = na;
            b = nb;
            c = nc;
            if (!chain && i != 39) begin
                if ($urandom_range(0, 1) == 1) tick();
                start_op(a, b, c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
